// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry in-order {pc, inst} queue decoupling fetch from decode.
// Optional statistics counters are enabled by defining IF_ID_QUEUE_STAT_EN.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_i,
  input  logic [ADDR_W-1:0]          if_pc_i,
  input  logic [INST_W-1:0]          if_inst_i,
  output logic                       if_ready_o,
  input  logic                       id_b_flag_i,
  input  logic                       ex_b_flag_i,
  input  logic                       id_stall_i,
  output logic                       id_valid_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [INST_W-1:0]          id_inst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef IF_ID_QUEUE_STAT_EN
  ,
  output logic [31:0]                stat_flush_o,
  output logic [31:0]                stat_stall_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic flush, push, pop;

  assign flush      = id_b_flag_i | ex_b_flag_i;
  assign if_ready_o = (count_reg < CW'(DEPTH));
  assign id_valid_o = (count_reg != '0);
  assign push       = if_valid_i & if_ready_o;
  assign pop        = id_valid_o & ~id_stall_i;
  assign count_o    = count_reg;

  // Empty queue presents an all-zero bubble so stale array contents never leak.
  assign id_pc_o   = id_valid_o ? pc_mem[rd_ptr_reg]   : '0;
  assign id_inst_o = id_valid_o ? inst_mem[rd_ptr_reg] : '0;

  // Storage is not reset; a flushed push is never written.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst && !flush && push && (wr_ptr_reg == PW'(gi))) begin
          pc_mem[gi]   <= if_pc_i;
          inst_mem[gi] <= if_inst_i;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

`ifdef IF_ID_QUEUE_STAT_EN
  logic [31:0] stat_flush_reg, stat_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flush_reg <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (flush && id_valid_o)      stat_flush_reg <= stat_flush_reg + 32'd1;
      if (id_valid_o && id_stall_i) stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_flush_o = stat_flush_reg;
  assign stat_stall_o = stat_stall_reg;
`endif

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF/ID decoupling stage: a DEPTH-entry in-order instruction queue between fetch and decode, replacing the single-entry IF/ID register.
- Fetch pushes {pc, inst} pairs with a valid/ready handshake. Decode consumes the head entry unless it stalls.
- A branch flag from ID or EX flushes every queued entry. When the queue is empty, decode sees a zero-word bubble.

Parameters:
- ADDR_W, 32, width of the pc field.
- INST_W, 32, width of the instruction field.
- DEPTH, 4, number of queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- if_valid_i  in  1  fetch presents an instruction this cycle.
- if_pc_i  in  ADDR_W  pc of the fetched instruction.
- if_inst_i  in  INST_W  fetched instruction word.
- if_ready_o  out  1  queue accepts a push this cycle.
- id_b_flag_i  in  1  branch taken, resolved in ID; flush.
- ex_b_flag_i  in  1  branch taken, resolved in EX; flush.
- id_stall_i  in  1  decode cannot consume this cycle.
- id_valid_o  out  1  head entry valid.
- id_pc_o  out  ADDR_W  head pc; zero when empty.
- id_inst_o  out  INST_W  head instruction; zero when empty.
- count_o  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset: synchronous, active-high, highest priority. Clears rd_ptr, wr_ptr and count to 0. After reset: if_ready_o=1, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0.
- Storage: DEPTH x (ADDR_W+INST_W) register array, plus rd_ptr/wr_ptr of width $clog2(DEPTH). Both pointers wrap modulo DEPTH. Array contents are not reset.
- if_ready_o = (count < DEPTH). It depends only on registered state and never on id_stall_i or the flush inputs.
- push = if_valid_i & if_ready_o.
- pop = id_valid_o & ~id_stall_i.
- id_valid_o = (count != 0).
- id_pc_o / id_inst_o: head entry when id_valid_o=1, otherwise all zeros (NOP bubble). No X is ever driven.
- Latency: an entry pushed into an empty queue at edge N appears on the id_* outputs in cycle N+1. Zero-cycle bypass does not exist.
- Order: strictly FIFO.
- flush = id_b_flag_i | ex_b_flag_i. Priority per edge: rst > flush > push/pop.
  - On flush: count <- 0 and rd_ptr <- wr_ptr. A same-cycle push is discarded and a same-cycle pop is ignored.
  - The cycle after flush: id_valid_o=0, outputs zero, if_ready_o=1.
- Simultaneous push and pop (count between 1 and DEPTH-1): both pointers advance and count is unchanged.
- Full (count=DEPTH): if_ready_o=0 and if_valid_i is ignored. A pop in that cycle drops count to DEPTH-1, so if_ready_o=1 in the next cycle.
- Empty: pop is impossible and id_stall_i has no effect.
- Stall: id_stall_i=1 holds the head entry and the outputs stable. Pushes still proceed until the queue is full.
- Flush while stalled: the flush still clears the queue.

Optional Feature:
- Macro: IF_ID_QUEUE_STAT_EN.
- Defined: adds two outputs.
  - stat_flush_o (32 bits): counts edges where flush=1 and count!=0.
  - stat_stall_o (32 bits): counts edges where id_valid_o & id_stall_i.
  - Both clear on rst and wrap modulo 2^32.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with if_valid_i=1 -> count_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, if_ready_o=1.
- Fill under stall: id_stall_i=1, push pc 0x100/0x104/0x108/0x10C -> count_o=4, if_ready_o=0. A fifth push of 0x110 is ignored. Head stays pc=0x100.
- Ordered drain: release stall -> id_pc_o sequence 0x100, 0x104, 0x108, 0x10C on consecutive cycles, then id_valid_o=0 and outputs zero.
- Flush priority: count=3, assert ex_b_flag_i together with push 0x200 and pop -> next cycle count_o=0, id_valid_o=0, id_inst_o=0. A following push of 0x300 appears as the head one cycle later.
- Concurrent push/pop and wrap: with count=2, push and pop every cycle for 10 cycles (pointers wrap more than twice) -> count_o stays 2 and output pcs stay in order.
- With IF_ID_QUEUE_STAT_EN defined: 3 non-empty flushes, 1 empty flush and 5 stalled-valid cycles -> stat_flush_o=3, stat_stall_o=5.
